// File: rtl/axil_decerr_responder.sv
// axil_decerr_responder
//   Default slave for the AXI-Lite interconnect's no-match port. Accepts
//   reads and writes whose address decoded to no slave, answers each with a
//   fixed error response (and fixed read data), and keeps debug statistics.
//
// Ports
//   aclk, aresetn          clock, synchronous active-low reset
//   slv_invalid_wr/rd      interconnect flags: current AW/W or AR is unmapped
//   s_axil_aw*/w*/b*       AXI-Lite write channels (wdata/wstrb ignored)
//   s_axil_ar*/r*          AXI-Lite read channels
//   err_count              saturating count of accepted AR + AW
//   last_err_addr          address of most recent accepted AR/AW
//   last_err_wr            1 when last_err_addr came from AW
module axil_decerr_responder #(
  parameter int unsigned              AXI_ADDR_WIDTH  = 32,
  parameter int unsigned              AXI_DATA_WIDTH  = 32,
  parameter int unsigned              MAX_OUTSTANDING = 4,
  parameter logic [1:0]               ERR_RESP        = 2'b11,
  parameter logic [AXI_DATA_WIDTH-1:0] RD_DATA        = '1,
  parameter int unsigned              CNT_WIDTH       = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          slv_invalid_wr,
  input  logic                          slv_invalid_rd,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic                          s_axil_awvalid,
  output logic                          s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                          s_axil_wvalid,
  output logic                          s_axil_wready,
  output logic [1:0]                    s_axil_bresp,
  output logic                          s_axil_bvalid,
  input  logic                          s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic                          s_axil_arvalid,
  output logic                          s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                    s_axil_rresp,
  output logic                          s_axil_rvalid,
  input  logic                          s_axil_rready,
  output logic [CNT_WIDTH-1:0]          err_count,
  output logic [AXI_ADDR_WIDTH-1:0]     last_err_addr,
  output logic                          last_err_wr
);

  localparam int unsigned OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);

  logic [OW-1:0]             r_rd_cnt, r_aw_cnt, r_w_cnt;
  logic [OW-1:0]             w_rd_next, w_aw_next, w_w_next;
  logic                      r_rvalid, r_bvalid;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                r_rresp, r_bresp;
  logic [CNT_WIDTH-1:0]      r_err_count;
  logic [AXI_ADDR_WIDTH-1:0] r_last_addr;
  logic                      r_last_wr;

  logic w_ar_acc, w_aw_acc, w_w_acc, w_r_hs, w_b_hs;
  logic [CNT_WIDTH:0] w_cnt_sum;
  logic w_unused_wpayload;

  assign w_unused_wpayload = ^{s_axil_wdata, s_axil_wstrb};

  // Readies are gated by reset so nothing is accepted while held in reset.
  assign s_axil_arready = aresetn && slv_invalid_rd && (r_rd_cnt < MAX_O);
  assign s_axil_awready = aresetn && slv_invalid_wr && (r_aw_cnt < MAX_O);
  assign s_axil_wready  = aresetn && slv_invalid_wr && (r_w_cnt  < MAX_O);

  assign w_ar_acc = s_axil_arvalid && s_axil_arready;
  assign w_aw_acc = s_axil_awvalid && s_axil_awready;
  assign w_w_acc  = s_axil_wvalid  && s_axil_wready;
  assign w_r_hs   = r_rvalid && s_axil_rready;
  assign w_b_hs   = r_bvalid && s_axil_bready;

  // rvalid mirrors (rd_cnt != 0), so a handshake never underflows rd_cnt;
  // likewise bvalid implies both aw_cnt and w_cnt are non-zero.
  assign w_rd_next = r_rd_cnt + OW'(w_ar_acc) - OW'(w_r_hs);
  assign w_aw_next = r_aw_cnt + OW'(w_aw_acc) - OW'(w_b_hs);
  assign w_w_next  = r_w_cnt  + OW'(w_w_acc)  - OW'(w_b_hs);

  // One extra bit catches overflow for the +2 case as well as +1.
  assign w_cnt_sum = {1'b0, r_err_count} + (CNT_WIDTH+1)'(w_ar_acc)
                                         + (CNT_WIDTH+1)'(w_aw_acc);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rd_cnt    <= '0;
      r_aw_cnt    <= '0;
      r_w_cnt     <= '0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_rresp     <= '0;
      r_bvalid    <= 1'b0;
      r_bresp     <= '0;
      r_err_count <= '0;
      r_last_addr <= '0;
      r_last_wr   <= 1'b0;
    end else begin
      r_rd_cnt <= w_rd_next;
      r_aw_cnt <= w_aw_next;
      r_w_cnt  <= w_w_next;

      r_rvalid <= (w_rd_next != '0);
      r_rdata  <= (w_rd_next != '0) ? RD_DATA  : '0;
      r_rresp  <= (w_rd_next != '0) ? ERR_RESP : '0;

      r_bvalid <= (w_aw_next != '0) && (w_w_next != '0);
      r_bresp  <= ((w_aw_next != '0) && (w_w_next != '0)) ? ERR_RESP : '0;

      r_err_count <= w_cnt_sum[CNT_WIDTH] ? '1 : w_cnt_sum[CNT_WIDTH-1:0];

      // Write address wins when AR and AW are accepted together.
      if (w_aw_acc) begin
        r_last_addr <= s_axil_awaddr;
        r_last_wr   <= 1'b1;
      end else if (w_ar_acc) begin
        r_last_addr <= s_axil_araddr;
        r_last_wr   <= 1'b0;
      end
    end
  end

  assign s_axil_rvalid = r_rvalid;
  assign s_axil_rdata  = r_rdata;
  assign s_axil_rresp  = r_rresp;
  assign s_axil_bvalid = r_bvalid;
  assign s_axil_bresp  = r_bresp;
  assign err_count     = r_err_count;
  assign last_err_addr = r_last_addr;
  assign last_err_wr   = r_last_wr;

endmodule

// File: tb/tb_axil_decerr_responder.sv
// tb_axil_decerr_responder
//   Randomized bench with a queue-based reference model. Stimulus is driven
//   1 time unit after each rising edge; the monitor samples on the falling
//   edge, checks the DUT against the model, then advances the model by the
//   handshakes that the next rising edge will complete.
module tb_axil_decerr_responder;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MO = 4;
  localparam int unsigned CW = 4;
  localparam logic [1:0]  ERR = 2'b11;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic inv_wr = 1'b0, inv_rd = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid, last_wr;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;
  logic [CW-1:0] err_count;
  logic [AW-1:0] last_addr;

  always #5 aclk = ~aclk;

  axil_decerr_responder #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .MAX_OUTSTANDING(MO),
    .ERR_RESP(ERR), .RD_DATA({DW{1'b1}}), .CNT_WIDTH(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .slv_invalid_wr(inv_wr), .slv_invalid_rd(inv_rd),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
    .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
    .s_axil_rready(rready),
    .err_count(err_count), .last_err_addr(last_addr), .last_err_wr(last_wr)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rexp_t;

  rexp_t        rq[$];    // expected R beats, one per accepted AR
  logic [1:0]   bq[$];    // expected B responses, one per accepted AW
  int           w_pend;   // accepted W beats not yet answered
  int           exp_cnt;
  logic [AW-1:0] exp_addr;
  logic         exp_wr;

  int  n_cmp = 0, n_err = 0;
  int  n_rbeats = 0, n_bbeats = 0, n_sat = 0;
  logic check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge aclk) begin
    logic e_rv, e_bv, e_arr, e_awr, e_wr, ar_acc, aw_acc, w_acc, r_hs, b_hs;
    rexp_t re;
    logic [1:0] be;
    e_rv  = rq.size() != 0;
    e_bv  = (bq.size() != 0) && (w_pend != 0);
    e_arr = aresetn && inv_rd && (rq.size() < MO);
    e_awr = aresetn && inv_wr && (bq.size() < MO);
    e_wr  = aresetn && inv_wr && (w_pend < MO);
    if (check_en) begin
      chk("rvalid",  rvalid,  e_rv);
      chk("bvalid",  bvalid,  e_bv);
      chk("arready", arready, e_arr);
      chk("awready", awready, e_awr);
      chk("wready",  wready,  e_wr);
      chk("err_count", err_count, exp_cnt);
      chk("last_err_addr", last_addr, exp_addr);
      chk("last_err_wr", last_wr, exp_wr);
      if (!e_rv) begin
        chk("rdata_idle", rdata, 0);
        chk("rresp_idle", rresp, 0);
      end
      if (!e_bv) chk("bresp_idle", bresp, 0);
    end
    if (!aresetn) begin
      rq.delete(); bq.delete(); w_pend = 0;
      exp_cnt = 0; exp_addr = '0; exp_wr = 1'b0;
    end else begin
      ar_acc = arvalid && e_arr;
      aw_acc = awvalid && e_awr;
      w_acc  = wvalid  && e_wr;
      r_hs   = e_rv && rready;
      b_hs   = e_bv && bready;
      if (r_hs) begin
        re = rq.pop_front();
        n_rbeats++;
        if (check_en) begin
          chk("rdata", rdata, re.data);
          chk("rresp", rresp, re.resp);
        end
      end
      if (b_hs) begin
        be = bq.pop_front();
        w_pend--;
        n_bbeats++;
        if (check_en) chk("bresp", bresp, be);
      end
      if (ar_acc) rq.push_back('{data: {DW{1'b1}}, resp: ERR});
      if (aw_acc) bq.push_back(ERR);
      if (w_acc) w_pend++;
      exp_cnt = exp_cnt + int'(ar_acc) + int'(aw_acc);
      if (exp_cnt >= CNT_MAX) begin
        if (exp_cnt > CNT_MAX) n_sat++;
        exp_cnt = CNT_MAX;
      end
      if (aw_acc) begin
        exp_addr = awaddr; exp_wr = 1'b1;
      end else if (ar_acc) begin
        exp_addr = araddr; exp_wr = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic rand_drive(input int cyc);
    inv_rd  = $urandom_range(0, 7) != 0;
    inv_wr  = $urandom_range(0, 7) != 0;
    arvalid = $urandom_range(0, 1);
    awvalid = $urandom_range(0, 2) == 0;
    wvalid  = $urandom_range(0, 2) == 0;
    rready  = $urandom_range(0, 3) != 0;
    bready  = $urandom_range(0, 3) != 0;
    araddr  = $urandom;
    awaddr  = $urandom;
    wdata   = $urandom;
    wstrb   = 4'($urandom);
    // occasional long stalls let the channels fill to capacity
    if ((cyc % 200) < 20) begin
      rready = 1'b0;
      bready = 1'b0;
    end
  endtask

  initial begin
    int waited;
    aresetn = 1'b0;
    repeat (3) step();
    check_en = 1'b1;          // reset state is checked from here on
    step();
    aresetn = 1'b1;

    // directed: single read, then W three cycles ahead of AW
    inv_rd = 1'b1; inv_wr = 1'b1; rready = 1'b1; bready = 1'b0;
    arvalid = 1'b1; araddr = 32'hDEAD_0000;
    step();
    arvalid = 1'b0;
    wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    repeat (3) step();
    awvalid = 1'b1; awaddr = 32'hBEEF_0004;
    step();
    awvalid = 1'b0;
    repeat (3) step();
    bready = 1'b1;
    step();
    bready = 1'b0;

    // directed: six ARs offered with rready low, then drain
    rready = 1'b0; arvalid = 1'b1;
    repeat (6) begin
      araddr = $urandom;
      step();
    end
    arvalid = 1'b0; rready = 1'b1;
    repeat (6) step();

    // randomized traffic with periodic stalls and a few random resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rand_drive(cyc);
      aresetn = ($urandom_range(0, 299) != 0);
      if (cyc == 1500) begin
        // reset while a write response is pending
        inv_wr = 1'b1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        waited = 0;
        while (!bvalid && waited < 50) begin
          step();
          waited++;
        end
        n_cmp++;
        if (!bvalid) begin
          n_err++;
          $display("FAIL bvalid_wait: got 0 expected 1 within 50 cycles");
        end
        aresetn = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        aresetn = 1'b1;
      end
      step();
    end

    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rready = 1'b1; bready = 1'b1;
    repeat (20) step();
    chk("r_traffic_seen", n_rbeats > 50, 1);
    chk("b_traffic_seen", n_bbeats > 20, 1);
    chk("saturation_seen", n_sat > 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
